// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, FSM state encoding and latency counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I sub-word accesses.
// Store path merges right-aligned store data into the old word under a byte
// enable; load path selects the addressed lane and sign/zero extends it.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] store_word,
  output logic [WIDTH-1:0] load_data
);

  logic [3:0]        byte_en;
  logic [WIDTH-1:0]  lane_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Store path: replicate the sub-word across lanes, then merge enabled lanes
  always_comb begin
    byte_en   = 4'b1111;
    lane_data = wdata;
    unique case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = wdata;
      end
    endcase
    store_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) store_word[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? old_word[WIDTH-1:16] : old_word[15:0];
  assign byte_s   = byte_sel;
  assign half_s   = half_sel;

  // Load path: pick the addressed lane and extend according to funct3
  always_comb begin
    load_data = old_word;
    unique case (funct3)
      F3_B:    load_data = WIDTH'(byte_s);
      F3_BU:   load_data = WIDTH'(byte_sel);
      F3_H:    load_data = WIDTH'(half_s);
      F3_HU:   load_data = WIDTH'(half_sel);
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data RAM responder for RV32I core loads/stores with a
// valid/ready request/response handshake and configurable latency.
// Optional feature: define DMEM_ERR_COUNT_EN to add a saturating 16-bit
// err_count output counting error responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_funct3,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
`ifdef DMEM_ERR_COUNT_EN
  output logic             resp_err,
  output logic [15:0]      err_count
`else
  output logic             resp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WIDTH-3:0] DEPTH_LIM = (WIDTH-2)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  state_t state, next_state;
  logic [CNT_W-1:0] cnt;

  logic             lat_write;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [2:0]       lat_funct3;

  logic             acc_write;
  logic [WIDTH-1:0] acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic [2:0]       acc_funct3;
  logic             acc_err;
  logic             width_bad, misalign, range_bad;

  logic             accept, enter_resp;
  logic [IDX_W-1:0] word_idx;
  logic [WIDTH-1:0] old_word, store_word, load_data;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (next_state == RESP) && (state != RESP);

  // With LATENCY=1 the access happens on the accept edge, so the live
  // request fields are used instead of the (not yet loaded) latches.
  assign acc_write  = (state == IDLE) ? req_write  : lat_write;
  assign acc_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;

  // Fault decode: illegal width, misalignment, address beyond the RAM
  always_comb begin
    width_bad = 1'b0;
    misalign  = 1'b0;
    unique case (acc_funct3)
      F3_B:  ;
      F3_H:  misalign = acc_addr[0];
      F3_W:  misalign = |acc_addr[1:0];
      F3_BU: width_bad = acc_write;
      F3_HU: begin
        width_bad = acc_write;
        misalign  = acc_addr[0];
      end
      default: width_bad = 1'b1;
    endcase
    range_bad = (acc_addr[WIDTH-1:2] >= DEPTH_LIM);
    acc_err   = width_bad | misalign | range_bad;
  end

  assign word_idx = acc_addr[IDX_W+1:2];
  assign old_word = mem[word_idx];

  dmem_lane_align #(
    .WIDTH(WIDTH)
  ) u_lane_align (
    .old_word  (old_word),
    .wdata     (acc_wdata),
    .addr_lo   (acc_addr[1:0]),
    .funct3    (acc_funct3),
    .store_word(store_word),
    .load_data (load_data)
  );

  // State register and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (accept)             cnt <= CNT_LOAD;
      else if (state == WAIT) cnt <= cnt - CNT_W'(1);
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      lat_funct3 <= req_funct3;
    end
  end

  // Response registers, loaded on the edge entering RESP and held until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || acc_write) ? '0 : load_data;
    end
  end

  // Store commit on the edge entering RESP; dropped by reset or fault
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_write && !acc_err) mem[word_idx] <= store_word;
  end

`ifdef DMEM_ERR_COUNT_EN
  // Saturating count of error responses
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (enter_resp && acc_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-addressed reference model.
module tb_dmem_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef DMEM_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mbytes [0:1023];
  int          m_errs = 0;
  logic        exp_err;
  logic [31:0] exp_rd;
  bit          exp_live = 1'b0;

  dmem_responder #(
    .WIDTH(32),
    .DEPTH_WORDS(256),
    .LATENCY(LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
`ifdef DMEM_ERR_COUNT_EN
    .resp_err  (resp_err),
    .err_count (err_count)
`else
    .resp_err  (resp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, rules applied with plain arithmetic
  function automatic void model_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                                       input logic [2:0] f3, output bit e, output logic [31:0] r);
    int sz = 0;
    bit sgn = 0;
    bit load_only = 0;
    longint v = 0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: begin sz = 4; sgn = 0; end
      3'd4: begin sz = 1; load_only = 1; end
      3'd5: begin sz = 2; load_only = 1; end
      default: sz = 0;
    endcase
    e = (sz == 0) || (w && load_only) || ((a % sz) != 0) || ((a / 4) >= 256);
    r = 32'h0;
    if (e) begin
      m_errs++;
    end else if (w) begin
      for (int b = 0; b < sz; b++) mbytes[a + b] = d[8*b +: 8];
    end else begin
      for (int b = 0; b < sz; b++) v = v + (longint'(mbytes[a + b]) << (8 * b));
      if (sgn && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      r = v[31:0];
    end
  endfunction

  // Output checker: every cycle a response is presented it must match the model
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      chk("resp_blocks_req", 32'(req_ready), 32'h0);
      if (exp_live) begin
        chk("cyc_err", 32'(resp_err), 32'(exp_err));
        chk("cyc_rdata", resp_rdata, exp_rd);
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input bit rr, output int k);
    bit e;
    logic [31:0] r;
    model_access(w, a, d, f3, e, r);
    exp_err    = e;
    exp_rd     = r;
    exp_live   = 1'b1;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    resp_ready = rr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 32) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic txn(input string nm, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input bit e_lit, input logic [31:0] r_lit);
    int k;
    issue(w, a, d, f3, 1'b1, k);
    chk({nm, " model_err"}, 32'(exp_err), 32'(e_lit));
    chk({nm, " model_rd"}, exp_rd, r_lit);
    chk({nm, " latency"}, 32'(k), 32'(LATENCY));
    chk({nm, " err"}, 32'(resp_err), 32'(e_lit));
    chk({nm, " rdata"}, resp_rdata, r_lit);
    @(posedge clk); #1;
    chk({nm, " valid_drop"}, 32'(resp_valid), 32'h0);
    chk({nm, " ready_back"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    int k;
    logic [31:0] held;
    for (int i = 0; i < 1024; i++) mbytes[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'h1);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst err", 32'(resp_err), 32'h0);
`ifdef DMEM_ERR_COUNT_EN
    chk("rst err_count", 32'(err_count), 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    txn("SW 10",  1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0);
    txn("LW 10a", 0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADBEEF);
    txn("SB 11",  1, 32'h11, 32'h000000A5, 3'b000, 0, 32'h0);
    txn("LW 10b", 0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADA5EF);
    txn("LB 11",  0, 32'h11, 32'h0,        3'b000, 0, 32'hFFFFFFA5);
    txn("LBU 11", 0, 32'h11, 32'h0,        3'b100, 0, 32'h000000A5);
    txn("SH 12",  1, 32'h12, 32'h00008001, 3'b001, 0, 32'h0);
    txn("LH 12",  0, 32'h12, 32'h0,        3'b001, 0, 32'hFFFF8001);
    txn("LHU 12", 0, 32'h12, 32'h0,        3'b101, 0, 32'h00008001);
    txn("LW 13",  0, 32'h13, 32'h0,        3'b010, 1, 32'h0);
    txn("LW 400", 0, 32'h400, 32'h0,       3'b010, 1, 32'h0);
    txn("SW f3=4", 1, 32'h10, 32'h0,       3'b100, 1, 32'h0);
    txn("LW 10c", 0, 32'h10, 32'h0,        3'b010, 0, 32'h8001A5EF);
    chk("model errs", 32'(m_errs), 32'd3);
`ifdef DMEM_ERR_COUNT_EN
    chk("err_count 3", 32'(err_count), 32'd3);
`endif
    txn("LH 11",  0, 32'h11, 32'h0,        3'b001, 1, 32'h0);
    txn("f3=3",   0, 32'h10, 32'h0,        3'b011, 1, 32'h0);
    txn("SB 13",  1, 32'h13, 32'h000000FF, 3'b000, 0, 32'h0);
    txn("LB 13",  0, 32'h13, 32'h0,        3'b000, 0, 32'hFFFFFFFF);
    txn("LH 10",  0, 32'h10, 32'h0,        3'b001, 0, 32'hFFFFA5EF);

    // Backpressure: response held, new requests ignored
    issue(0, 32'h10, 32'h0, 3'b010, 1'b0, k);
    chk("bp latency", 32'(k), 32'(LATENCY));
    held = resp_rdata;
    chk("bp rdata", held, 32'hFF01A5EF);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
      req_wdata = 32'hBAD0BAD0; req_funct3 = 3'b010;
      @(posedge clk); #1;
      chk("bp valid", 32'(resp_valid), 32'h1);
      chk("bp hold", resp_rdata, held);
      chk("bp req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp done", 32'(resp_valid), 32'h0);
    txn("LW bp", 0, 32'h10, 32'h0, 3'b010, 0, 32'hFF01A5EF);

    // Reset while a response is presented
    issue(0, 32'h10, 32'h0, 3'b010, 1'b0, k);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstR valid", 32'(resp_valid), 32'h0);
    chk("rstR rdata", resp_rdata, 32'h0);
    chk("rstR ready", 32'(req_ready), 32'h1);
    resp_ready = 1'b1;

    // Reset during WAIT drops the store
    txn("SW 20", 1, 32'h20, 32'hCAFEF00D, 3'b010, 0, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstW in wait", 32'(req_ready), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstW ready", 32'(req_ready), 32'h1);
`ifdef DMEM_ERR_COUNT_EN
    chk("rstW err_count", 32'(err_count), 32'h0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstW no resp", 32'(resp_valid), 32'h0);
    end
    txn("LW 20", 0, 32'h20, 32'h0, 3'b010, 0, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
